do_view_change_eng_ctrl: RTL and testbench

//  New-primary side of VR view change: consumes DoViewChange (DVC) messages issued by peer view-change engines,

---
 rtl/do_view_change_eng_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_do_view_change_eng_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/do_view_change_eng_ctrl.sv
// rtl/do_view_change_eng_ctrl.sv - new-primary DoViewChange collector: quorum, best-log selection, StartView trigger
// Collects DVC messages per view, keeps the best log and max commit, and announces the new view on quorum.
module do_view_change_eng_ctrl #(
    parameter int NUM_REPLICAS = 3,
    parameter int REPLICA_W    = 2,
    parameter int VIEW_W       = 64,
    parameter int OP_W         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 manage_dvc_msg_val,
    output logic                 dvc_manage_msg_rdy,
    input  logic [VIEW_W-1:0]    manage_dvc_msg_view,
    input  logic [VIEW_W-1:0]    manage_dvc_msg_last_norm,
    input  logic [OP_W-1:0]      manage_dvc_msg_op,
    input  logic [OP_W-1:0]      manage_dvc_msg_commit,
    input  logic [REPLICA_W-1:0] manage_dvc_msg_src,
    input  logic                 manage_dvc_req_val,
    input  logic                 manage_dvc_req_last,
    output logic                 dvc_manage_req_rdy,
    output logic                 ctrl_logbuf_wr_start,
    output logic                 ctrl_logbuf_wr_val,
    output logic                 ctrl_logbuf_wr_last,
    input  logic                 logbuf_ctrl_wr_rdy,
    output logic                 dvc_start_view_val,
    input  logic                 start_view_dvc_rdy,
    output logic [VIEW_W-1:0]    dvc_start_view_view,
    output logic [OP_W-1:0]      dvc_start_view_op,
    output logic [OP_W-1:0]      dvc_start_view_commit,
    output logic                 vc_vr_state_wr_req,
    input  logic                 vr_state_vc_wr_req_rdy,
    output logic                 dvc_engine_rdy
);

    localparam int CNT_W = $clog2(NUM_REPLICAS + 1);
    localparam logic [CNT_W-1:0]   QUORUM_C = CNT_W'(NUM_REPLICAS / 2 + 1);
    localparam logic [REPLICA_W:0] NUM_R    = (REPLICA_W + 1)'(NUM_REPLICAS);

    typedef enum logic [2:0] {
        ST_READY,
        ST_CHECK_VIEW,
        ST_STORE_LOG,
        ST_DRAIN,
        ST_CHECK_QUORUM,
        ST_SEND_SV,
        ST_WR_STATE
    } state_t;

    state_t                  r_state;
    logic [VIEW_W-1:0]       r_act_view;
    logic [VIEW_W-1:0]       r_best_norm;
    logic [OP_W-1:0]         r_best_op;
    logic [OP_W-1:0]         r_max_commit;
    logic [NUM_REPLICAS-1:0] r_quorum_vec;
    logic                    r_done;
    logic                    r_kept;
    logic                    r_wr_start;
    logic [VIEW_W-1:0]       r_msg_view;
    logic [VIEW_W-1:0]       r_msg_norm;
    logic [OP_W-1:0]         r_msg_op;
    logic [OP_W-1:0]         r_msg_commit;
    logic [REPLICA_W-1:0]    r_msg_src;
    logic [VIEW_W-1:0]       r_sv_view;
    logic [OP_W-1:0]         r_sv_op;
    logic [OP_W-1:0]         r_sv_commit;

    logic                    w_new_view;
    logic                    w_src_ok;
    logic [NUM_REPLICAS-1:0] w_src_onehot;
    logic [NUM_REPLICAS-1:0] w_base_vec;
    logic                    w_discard;
    logic                    w_first;
    logic                    w_better;
    logic [OP_W-1:0]         w_commit_max;
    logic [CNT_W-1:0]        w_votes;
    logic                    w_quorum;

    // A higher view wipes the per-view bookkeeping, so the sender is judged against an empty quorum.
    assign w_new_view = r_msg_view > r_act_view;
    assign w_src_ok   = {1'b0, r_msg_src} < NUM_R;
    assign w_base_vec = w_new_view ? '0 : r_quorum_vec;
    assign w_first    = w_new_view | (r_quorum_vec == '0);

    always_comb begin
        w_src_onehot = '0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            w_src_onehot[i] = (r_msg_src == REPLICA_W'(i));
        end
    end

    assign w_discard = (r_msg_view < r_act_view)
                     | ((r_msg_view == r_act_view) & r_done)
                     | (|(w_src_onehot & w_base_vec))
                     | ~w_src_ok;

    assign w_better = w_first
                    | (r_msg_norm > r_best_norm)
                    | ((r_msg_norm == r_best_norm) & (r_msg_op > r_best_op));

    assign w_commit_max = (w_new_view || r_msg_commit > r_max_commit) ? r_msg_commit : r_max_commit;

    always_comb begin
        w_votes = '0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            w_votes = w_votes + CNT_W'(r_quorum_vec[i]);
        end
    end
    assign w_quorum = w_votes >= QUORUM_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_READY;
            r_act_view   <= '0;
            r_best_norm  <= '0;
            r_best_op    <= '0;
            r_max_commit <= '0;
            r_quorum_vec <= '0;
            r_done       <= 1'b0;
            r_kept       <= 1'b0;
            r_wr_start   <= 1'b0;
            r_msg_view   <= '0;
            r_msg_norm   <= '0;
            r_msg_op     <= '0;
            r_msg_commit <= '0;
            r_msg_src    <= '0;
            r_sv_view    <= '0;
            r_sv_op      <= '0;
            r_sv_commit  <= '0;
        end else begin
            r_wr_start <= 1'b0;
            case (r_state)
                ST_READY: begin
                    if (manage_dvc_msg_val) begin
                        r_msg_view   <= manage_dvc_msg_view;
                        r_msg_norm   <= manage_dvc_msg_last_norm;
                        r_msg_op     <= manage_dvc_msg_op;
                        r_msg_commit <= manage_dvc_msg_commit;
                        r_msg_src    <= manage_dvc_msg_src;
                        r_state      <= ST_CHECK_VIEW;
                    end
                end
                ST_CHECK_VIEW: begin
                    if (w_discard) begin
                        r_kept  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_kept       <= 1'b1;
                        r_act_view   <= r_msg_view;
                        r_quorum_vec <= w_base_vec | w_src_onehot;
                        r_max_commit <= w_commit_max;
                        r_done       <= 1'b0;
                        if (w_better) begin
                            r_best_norm <= r_msg_norm;
                            r_best_op   <= r_msg_op;
                            r_wr_start  <= 1'b1;
                            r_state     <= ST_STORE_LOG;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_STORE_LOG: begin
                    if (manage_dvc_req_val && logbuf_ctrl_wr_rdy && manage_dvc_req_last) begin
                        r_state <= ST_CHECK_QUORUM;
                    end
                end
                ST_DRAIN: begin
                    if (manage_dvc_req_val && manage_dvc_req_last) begin
                        r_state <= r_kept ? ST_CHECK_QUORUM : ST_READY;
                    end
                end
                ST_CHECK_QUORUM: begin
                    if (w_quorum) begin
                        r_done      <= 1'b1;
                        r_sv_view   <= r_act_view;
                        r_sv_op     <= r_best_op;
                        r_sv_commit <= r_max_commit;
                        r_state     <= ST_SEND_SV;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                ST_SEND_SV: begin
                    if (start_view_dvc_rdy) r_state <= ST_WR_STATE;
                end
                ST_WR_STATE: begin
                    if (vr_state_vc_wr_req_rdy) r_state <= ST_READY;
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign dvc_manage_msg_rdy    = (r_state == ST_READY);
    assign dvc_engine_rdy        = (r_state == ST_READY);
    assign dvc_manage_req_rdy    = (r_state == ST_DRAIN) | ((r_state == ST_STORE_LOG) & logbuf_ctrl_wr_rdy);
    assign ctrl_logbuf_wr_start  = r_wr_start;
    assign ctrl_logbuf_wr_val    = (r_state == ST_STORE_LOG) & manage_dvc_req_val;
    assign ctrl_logbuf_wr_last   = (r_state == ST_STORE_LOG) & manage_dvc_req_last;
    assign dvc_start_view_val    = (r_state == ST_SEND_SV);
    assign vc_vr_state_wr_req    = (r_state == ST_WR_STATE);
    assign dvc_start_view_view   = r_sv_view;
    assign dvc_start_view_op     = r_sv_op;
    assign dvc_start_view_commit = r_sv_commit;

endmodule

// File: tb/tb_do_view_change_eng_ctrl.sv
// tb/tb_do_view_change_eng_ctrl.sv - self-checking bench for do_view_change_eng_ctrl
// Directed vector table, hand sequences for stalls and reset, then random traffic against a transaction model.
module tb_do_view_change_eng_ctrl;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msg_val = 1'b0;
    logic        msg_rdy;
    logic [63:0] msg_view = '0, msg_norm = '0, msg_op = '0, msg_commit = '0;
    logic [1:0]  msg_src = '0;
    logic        req_val = 1'b0, req_last = 1'b0, req_rdy;
    logic        lb_start, lb_val, lb_last;
    logic        lb_rdy = 1'b1;
    logic        sv_val;
    logic        sv_rdy = 1'b0;
    logic [63:0] sv_view, sv_op, sv_commit;
    logic        st_req;
    logic        st_rdy = 1'b0;
    logic        eng_rdy;

    always #5 clk = ~clk;

    do_view_change_eng_ctrl #(.NUM_REPLICAS(N), .REPLICA_W(2), .VIEW_W(64), .OP_W(64)) dut (
        .clk(clk), .rst(rst),
        .manage_dvc_msg_val(msg_val), .dvc_manage_msg_rdy(msg_rdy),
        .manage_dvc_msg_view(msg_view), .manage_dvc_msg_last_norm(msg_norm),
        .manage_dvc_msg_op(msg_op), .manage_dvc_msg_commit(msg_commit),
        .manage_dvc_msg_src(msg_src),
        .manage_dvc_req_val(req_val), .manage_dvc_req_last(req_last), .dvc_manage_req_rdy(req_rdy),
        .ctrl_logbuf_wr_start(lb_start), .ctrl_logbuf_wr_val(lb_val), .ctrl_logbuf_wr_last(lb_last),
        .logbuf_ctrl_wr_rdy(lb_rdy),
        .dvc_start_view_val(sv_val), .start_view_dvc_rdy(sv_rdy),
        .dvc_start_view_view(sv_view), .dvc_start_view_op(sv_op), .dvc_start_view_commit(sv_commit),
        .vc_vr_state_wr_req(st_req), .vr_state_vc_wr_req_rdy(st_rdy),
        .dvc_engine_rdy(eng_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sink side observation
    int          c_start = 0, c_beats = 0, c_sv = 0, c_st = 0, last_idx = 0;
    logic [63:0] got_view = '0, got_op = '0, got_commit = '0;
    logic [63:0] h_view = '0, h_op = '0, h_commit = '0;
    bit          p_sv_pend = 0, p_st_pend = 0;

    always @(negedge clk) begin
        if (rst) begin
            p_sv_pend = 0;
            p_st_pend = 0;
        end else begin
            if (lb_start) c_start++;
            if (lb_val && lb_rdy) begin
                c_beats++;
                if (lb_last) last_idx = c_beats;
            end
            if (p_sv_pend) begin
                check("sv_val_held", 64'(sv_val), 64'd1);
                check("sv_view_held", sv_view, h_view);
                check("sv_op_held", sv_op, h_op);
                check("sv_commit_held", sv_commit, h_commit);
            end
            if (sv_val && sv_rdy) begin
                c_sv++;
                got_view = sv_view; got_op = sv_op; got_commit = sv_commit;
            end
            p_sv_pend = sv_val && !sv_rdy;
            h_view = sv_view; h_op = sv_op; h_commit = sv_commit;
            if (p_st_pend) check("st_req_held", 64'(st_req), 64'd1);
            if (st_req && st_rdy) c_st++;
            p_st_pend = st_req && !st_rdy;
        end
    end

    // Downstream responders
    int lb_mode = 0, sv_delay = 0, st_delay = 0, sv_cnt = 0, st_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (sv_val) begin
            sv_rdy = (sv_cnt >= sv_delay);
            sv_cnt = sv_rdy ? 0 : sv_cnt + 1;
        end else begin
            sv_rdy = 1'b0; sv_cnt = 0;
        end
        if (st_req) begin
            st_rdy = (st_cnt >= st_delay);
            st_cnt = st_rdy ? 0 : st_cnt + 1;
        end else begin
            st_rdy = 1'b0; st_cnt = 0;
        end
        case (lb_mode)
            0: lb_rdy = 1'b1;
            1: lb_rdy = ~lb_rdy;
            default: lb_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Transaction-level model of the view-change rules
    logic [63:0] m_view, m_norm, m_op, m_commit;
    bit          m_done;
    int          m_voters[$];

    task automatic model_reset();
        m_view = '0; m_norm = '0; m_op = '0; m_commit = '0; m_done = 0;
        m_voters.delete();
    endtask

    task automatic model_msg(input logic [63:0] v, n, o, c, input logic [1:0] s,
                             output bit st, output bit sv, output logic [63:0] ev, eo, ec);
        bit first, seen;
        st = 0; sv = 0; ev = '0; eo = '0; ec = '0;
        if (int'(s) >= N || v < m_view) return;
        if (v > m_view) begin
            m_view = v; m_done = 0; m_norm = '0; m_op = '0; m_commit = '0;
            m_voters.delete();
        end
        if (m_done) return;
        seen = 0;
        foreach (m_voters[i]) if (m_voters[i] == int'(s)) seen = 1;
        if (seen) return;
        first = (m_voters.size() == 0);
        m_voters.push_back(int'(s));
        if (c > m_commit) m_commit = c;
        if (first || n > m_norm || (n == m_norm && o > m_op)) begin
            st = 1; m_norm = n; m_op = o;
        end
        if (m_voters.size() >= N / 2 + 1) begin
            m_done = 1; sv = 1; ev = m_view; eo = m_op; ec = m_commit;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        msg_val = 1'b0; req_val = 1'b0; req_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one DVC; abort_at >= 0 leaves that beat pending and returns early.
    task automatic send_msg(input logic [63:0] v, n, o, c, input logic [1:0] s,
                            input int beats, input int abort_at);
        int t;
        t = 0;
        while (!msg_rdy && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) check("msg_rdy_timeout", 64'(msg_rdy), 64'd1);
        msg_view = v; msg_norm = n; msg_op = o; msg_commit = c; msg_src = s;
        msg_val = 1'b1;
        @(posedge clk); #1;
        msg_val = 1'b0;
        for (int b = 0; b < beats; b++) begin
            req_val = 1'b1;
            req_last = (b == beats - 1);
            if (b == abort_at) return;
            t = 0;
            forever begin
                @(negedge clk);
                if (req_rdy || t > 200) break;
                t++;
            end
            if (t > 200) check("req_rdy_timeout", 64'(req_rdy), 64'd1);
            @(posedge clk); #1;
        end
        req_val = 1'b0; req_last = 1'b0;
        t = 0;
        while (!eng_rdy && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) check("engine_rdy_timeout", 64'(eng_rdy), 64'd1);
    endtask

    task automatic run_check(input string tag, input logic [63:0] v, n, o, c, input logic [1:0] s,
                             input int beats, input bit est, input bit esv,
                             input logic [63:0] ev, eo, ec);
        int s0, b0, v0, t0;
        s0 = c_start; b0 = c_beats; v0 = c_sv; t0 = c_st;
        send_msg(v, n, o, c, s, beats, -1);
        check({tag, "_wr_start"}, 64'(c_start - s0), 64'(est));
        check({tag, "_beats"}, 64'(c_beats - b0), est ? 64'(beats) : 64'd0);
        check({tag, "_start_view"}, 64'(c_sv - v0), 64'(esv));
        check({tag, "_state_wr"}, 64'(c_st - t0), 64'(esv));
        if (esv) begin
            check({tag, "_sv_view"}, got_view, ev);
            check({tag, "_sv_op"}, got_op, eo);
            check({tag, "_sv_commit"}, got_commit, ec);
        end
    endtask

    task automatic run_model(input string tag, input logic [63:0] v, n, o, c, input logic [1:0] s,
                             input int beats);
        bit est, esv;
        logic [63:0] ev, eo, ec;
        model_msg(v, n, o, c, s, est, esv, ev, eo, ec);
        run_check(tag, v, n, o, c, s, beats, est, esv, ev, eo, ec);
    endtask

    typedef struct {
        bit          rst_before;
        logic [63:0] view, norm, op, commit;
        logic [1:0]  src;
        bit          exp_store, exp_sv;
        logic [63:0] exp_view, exp_op, exp_commit;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 64'd5, 64'd4, 64'd10, 64'd8,  2'd1, 1'b1, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[1]  = '{1'b0, 64'd5, 64'd4, 64'd12, 64'd9,  2'd2, 1'b1, 1'b1, 64'd5, 64'd12, 64'd9};
        tbl[2]  = '{1'b0, 64'd4, 64'd9, 64'd99, 64'd99, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[3]  = '{1'b0, 64'd5, 64'd9, 64'd99, 64'd99, 2'd0, 1'b0, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[4]  = '{1'b1, 64'd5, 64'd4, 64'd10, 64'd8,  2'd1, 1'b1, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[5]  = '{1'b0, 64'd5, 64'd4, 64'd20, 64'd8,  2'd1, 1'b0, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[6]  = '{1'b0, 64'd5, 64'd3, 64'd15, 64'd2,  2'd0, 1'b0, 1'b1, 64'd5, 64'd10, 64'd8};
        tbl[7]  = '{1'b1, 64'd5, 64'd4, 64'd10, 64'd8,  2'd1, 1'b1, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[8]  = '{1'b0, 64'd6, 64'd2, 64'd3,  64'd4,  2'd0, 1'b1, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[9]  = '{1'b0, 64'd6, 64'd2, 64'd3,  64'd1,  2'd2, 1'b0, 1'b1, 64'd6, 64'd3,  64'd4};
        tbl[10] = '{1'b1, 64'd1, 64'd0, 64'd0,  64'd7,  2'd3, 1'b0, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[11] = '{1'b0, 64'd1, 64'd0, 64'd0,  64'd2,  2'd0, 1'b1, 1'b0, 64'd0, 64'd0,  64'd0};
        tbl[12] = '{1'b0, 64'd1, 64'd0, 64'd1,  64'd3,  2'd1, 1'b1, 1'b1, 64'd1, 64'd1,  64'd3};

        do_reset();
        check("reset_engine_rdy", 64'(eng_rdy), 64'd1);
        check("reset_msg_rdy", 64'(msg_rdy), 64'd1);
        check("reset_sv_val", 64'(sv_val), 64'd0);
        check("reset_state_wr", 64'(st_req), 64'd0);
        check("reset_wr_start", 64'(lb_start), 64'd0);
        check("reset_sv_op", sv_op, 64'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            run_check($sformatf("vec%0d", i), tbl[i].view, tbl[i].norm, tbl[i].op, tbl[i].commit,
                      tbl[i].src, 2, tbl[i].exp_store, tbl[i].exp_sv,
                      tbl[i].exp_view, tbl[i].exp_op, tbl[i].exp_commit);
        end

        // 8-beat store under a toggling log buffer, StartView accepted 5 cycles late
        do_reset();
        lb_mode = 1; sv_delay = 5; st_delay = 2;
        begin
            int b0;
            b0 = c_beats;
            run_check("stall_store", 64'd5, 64'd1, 64'd7, 64'd3, 2'd0, 8, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
            check("stall_last_on_beat8", 64'(last_idx - b0), 64'd8);
            run_check("stall_sv", 64'd5, 64'd0, 64'd9, 64'd4, 2'd1, 1, 1'b0, 1'b1, 64'd5, 64'd7, 64'd4);
        end
        lb_mode = 0; sv_delay = 0; st_delay = 0;

        // Reset while the third payload beat is pending
        do_reset();
        send_msg(64'd5, 64'd1, 64'd1, 64'd1, 2'd1, 5, 2);
        check("pre_rst_logbuf_val", 64'(lb_val), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_engine_rdy", 64'(eng_rdy), 64'd1);
        check("rst_mid_logbuf_val", 64'(lb_val), 64'd0);
        check("rst_mid_req_rdy", 64'(req_rdy), 64'd0);
        check("rst_mid_sv_val", 64'(sv_val), 64'd0);
        check("rst_mid_state_wr", 64'(st_req), 64'd0);
        req_val = 1'b0; req_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_model("post_rst_a", 64'd2, 64'd1, 64'd4, 64'd2, 2'd0, 3);
        run_model("post_rst_b", 64'd2, 64'd1, 64'd6, 64'd1, 2'd2, 2);

        // Random traffic against the model
        do_reset();
        lb_mode = 2;
        for (int k = 0; k < 60; k++) begin
            logic [63:0] v;
            int r;
            r = $urandom_range(0, 9);
            if (r == 0 && m_view > 0) v = m_view - 1;
            else if (r < 4) v = m_view + 1;
            else v = m_view;
            sv_delay = $urandom_range(0, 3);
            st_delay = $urandom_range(0, 2);
            run_model($sformatf("rnd%0d", k), v, 64'($urandom_range(0, 3)), 64'($urandom_range(0, 7)),
                      64'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
